// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer register file and its writeback path.
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_CNT_W = 4;

  // One writeback request as seen by the arbiter.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Which requester wins when both ex and lsu want the write port.
  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_EX  = 1'b1
  } prio_t;

  // One-hot register select. x0 never maps to a bit because it is never tracked.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    mask[0]    = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set when
// decode issues a writer and cleared when the registered write stage commits it.
module wb_scoreboard (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr_en,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]    clr_addr,
  input  logic                                issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]    issue_rd,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]    rs1_addr,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]    rs2_addr,
  output logic                                issue_ready,
  output logic                                hazard,
  output logic [riscv_pkg::NUM_REGS-1:0]      busy_mask
);
  import riscv_pkg::*;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Issue and hazard checks look only at the registered bits, so a bit being
  // cleared this cycle still blocks a new writer to the same register.
  always_comb begin
    issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
    hazard      = ((rs1_addr != '0) && busy_q[rs1_addr]) ||
                  ((rs2_addr != '0) && busy_q[rs2_addr]);
    set_mask    = (issue_valid && issue_ready) ? reg_onehot(issue_rd) : '0;
    clr_mask    = clr_en ? reg_onehot(clr_addr) : '0;
  end

  // Busy bits: clear on commit, then set on issue so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ex and lsu writeback, with a
// starvation guard for ex and one registered stage in front of the regfile.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ex_valid,
  output logic                              ex_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  ex_rd,
  input  logic [XLEN-1:0]                   ex_data,
  input  logic                              lsu_valid,
  output logic                              lsu_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  lsu_rd,
  input  logic [XLEN-1:0]                   lsu_data,
  input  logic                              issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rd,
  output logic                              issue_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  rs1_addr,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  rs2_addr,
  output logic                              hazard,
  output logic [riscv_pkg::NUM_REGS-1:0]    busy_mask,
  output logic                              rd_wren,
  output logic [riscv_pkg::REG_ADDR_W-1:0]  rd_addr,
  output logic [XLEN-1:0]                   rd_data
);
  import riscv_pkg::*;

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  prio_t                     state;
  prio_t                     state_next;
  logic [STARVE_CNT_W-1:0]   starve_cnt;
  logic [STARVE_CNT_W-1:0]   starve_cnt_next;
  logic                      ex_grant;
  logic                      lsu_grant;
  logic [REG_ADDR_W-1:0]     sel_rd;
  logic [XLEN-1:0]           sel_data;

  // Priority state and the count of consecutive ex losses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRIO_LSU;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Any ex grant forgives past losses; a contested lsu win adds one, capped at the limit.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (ex_grant) begin
      starve_cnt_next = '0;
    end else if (lsu_grant && ex_valid && (starve_cnt < STARVE_LIM)) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
    state_next = (starve_cnt_next == STARVE_LIM) ? PRIO_EX : PRIO_LSU;
  end

  // Grants: a lone requester always wins, contention goes to the priority holder.
  always_comb begin
    ex_grant  = ex_valid  && (!lsu_valid || (state == PRIO_EX));
    lsu_grant = lsu_valid && (!ex_valid  || (state == PRIO_LSU));
    ex_ready  = ex_grant;
    lsu_ready = lsu_grant;
    sel_rd    = ex_grant ? ex_rd   : lsu_rd;
    sel_data  = ex_grant ? ex_data : lsu_data;
  end

  // Registered write stage; x0 writes are accepted but never reach the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wren <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (ex_grant || lsu_grant) begin
      rd_wren <= (sel_rd != '0);
      rd_addr <= sel_rd;
      rd_data <= sel_data;
    end else begin
      rd_wren <= 1'b0;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .clr_en      (rd_wren),
    .clr_addr    (rd_addr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .issue_ready (issue_ready),
    .hazard      (hazard),
    .busy_mask   (busy_mask)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of grants, write stage and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic [31:0] busy_mask;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_busy;
  int          m_losses;
  logic        m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        exp_exg;
  logic        exp_lsug;
  logic        exp_ir;
  logic        exp_hz;

  // Values seen during the most recent step, for scenario-specific checks
  logic        obs_ex_ready;
  logic        obs_lsu_ready;
  logic        obs_issue_ready;
  logic        obs_hazard;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rd       (ex_rd),
    .ex_data     (ex_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard      (hazard),
    .busy_mask   (busy_mask),
    .rd_wren     (rd_wren),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_busy   = '0;
    m_losses = 0;
    m_wren   = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic setIdle();
    ex_valid    = 1'b0;
    ex_rd       = '0;
    ex_data     = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic applyStimulus(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                               input logic lsuv, input logic [4:0] lsurd, input logic [31:0] lsud,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    ex_valid    = exv;
    ex_rd       = exrd;
    ex_data     = exd;
    lsu_valid   = lsuv;
    lsu_rd      = lsurd;
    lsu_data    = lsud;
    issue_valid = iv;
    issue_rd    = ird;
    rs1_addr    = r1;
    rs2_addr    = r2;
    #2;
    // ex wins a contest only after losing STARVE_MAX contests in a row
    exp_exg  = exv && (!lsuv || (m_losses >= STARVE_MAX));
    exp_lsug = lsuv && !exp_exg;
    exp_ir   = (ird == 5'd0) || !m_busy[ird];
    exp_hz   = ((r1 != 5'd0) && m_busy[r1]) || ((r2 != 5'd0) && m_busy[r2]);
    obs_ex_ready    = ex_ready;
    obs_lsu_ready   = lsu_ready;
    obs_issue_ready = issue_ready;
    obs_hazard      = hazard;
    checkOutput("ex_ready",    {31'd0, ex_ready},    {31'd0, exp_exg});
    checkOutput("lsu_ready",   {31'd0, lsu_ready},   {31'd0, exp_lsug});
    checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ir});
    checkOutput("hazard",      {31'd0, hazard},      {31'd0, exp_hz});
    @(posedge clk);
    if (m_wren) m_busy[m_addr] = 1'b0;
    if (iv && exp_ir && (ird != 5'd0)) m_busy[ird] = 1'b1;
    if (exp_exg) m_losses = 0;
    else if (exp_lsug && exv) m_losses++;
    if (exp_exg) begin
      m_wren = (exrd != 5'd0);
      m_addr = exrd;
      m_data = exd;
    end else if (exp_lsug) begin
      m_wren = (lsurd != 5'd0);
      m_addr = lsurd;
      m_data = lsud;
    end else begin
      m_wren = 1'b0;
    end
    #1;
    checkOutput("rd_wren",   {31'd0, rd_wren}, {31'd0, m_wren});
    checkOutput("rd_addr",   {27'd0, rd_addr}, {27'd0, m_addr});
    checkOutput("rd_data",   rd_data,          m_data);
    checkOutput("busy_mask", busy_mask,        m_busy);
  endtask

  initial begin
    logic        ex_pend;
    logic        lsu_pend;
    logic [4:0]  n_exrd;
    logic [31:0] n_exd;
    logic [4:0]  n_lsurd;
    logic [31:0] n_lsud;
    logic [31:0] before_mask;

    setIdle();
    modelReset();
    rst = 1'b1;
    #3;
    $display("[TB] reset state");
    checkOutput("reset_rd_wren",     {31'd0, rd_wren},     32'd0);
    checkOutput("reset_rd_addr",     {27'd0, rd_addr},     32'd0);
    checkOutput("reset_rd_data",     rd_data,              32'd0);
    checkOutput("reset_busy_mask",   busy_mask,            32'd0);
    checkOutput("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("reset_hazard",      {31'd0, hazard},      32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single ex writeback");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("ex_only_ready", {31'd0, obs_ex_ready}, 32'd1);
    checkOutput("ex_only_wren",  {31'd0, rd_wren},      32'd1);
    checkOutput("ex_only_addr",  {27'd0, rd_addr},      32'd5);
    checkOutput("ex_only_data",  rd_data,               32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("ex_only_wren_drop", {31'd0, rd_wren}, 32'd0);
    checkOutput("ex_only_addr_hold", {27'd0, rd_addr}, 32'd5);

    $display("[TB] contention and starvation guard");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 5'd1, 32'h1000 + k, 1'b1, 5'd2, 32'h2000 + k, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("starve_pattern_ex", {31'd0, obs_ex_ready}, ((k == 4) ? 32'd1 : 32'd0));
    end

    $display("[TB] scoreboard hazard on rd 7");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    checkOutput("issue7_busy", {31'd0, busy_mask[7]}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    checkOutput("rs1_7_hazard",      {31'd0, obs_hazard},      32'd1);
    checkOutput("reissue7_blocked",  {31'd0, obs_issue_ready}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("lsu7_busy_still", {31'd0, busy_mask[7]}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("lsu7_busy_cleared", {31'd0, busy_mask[7]}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("rs1_7_no_hazard", {31'd0, obs_hazard}, 32'd0);

    $display("[TB] writes and issues to x0");
    before_mask = busy_mask;
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_ex_ready",     {31'd0, obs_ex_ready},    32'd1);
    checkOutput("x0_wren",         {31'd0, rd_wren},         32'd0);
    checkOutput("x0_issue_ready",  {31'd0, obs_issue_ready}, 32'd1);
    checkOutput("x0_busy_same",    busy_mask,                before_mask);

    $display("[TB] issue racing a clearing write on rd 3");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    checkOutput("race3_blocked",     {31'd0, obs_issue_ready}, 32'd0);
    checkOutput("race3_bit_cleared", {31'd0, busy_mask[3]},    32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    checkOutput("race3_accepted", {31'd0, obs_issue_ready}, 32'd1);
    checkOutput("race3_bit_set",  {31'd0, busy_mask[3]},    32'd1);

    $display("[TB] reset while a write is pending");
    applyStimulus(1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    checkOutput("midrst_pending", {31'd0, rd_wren}, 32'd1);
    #1;
    setIdle();
    rs1_addr = 5'd3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_wren",        {31'd0, rd_wren},     32'd0);
    checkOutput("midrst_busy",        busy_mask,            32'd0);
    checkOutput("midrst_issue_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("midrst_hazard",      {31'd0, hazard},      32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random traffic");
    ex_pend  = 1'b0;
    lsu_pend = 1'b0;
    n_exrd   = '0;
    n_exd    = '0;
    n_lsurd  = '0;
    n_lsud   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ex_pend) begin
        ex_pend = ($urandom_range(0, 99) < 60);
        n_exrd  = 5'($urandom_range(0, 31));
        n_exd   = $urandom;
      end
      if (!lsu_pend) begin
        lsu_pend = ($urandom_range(0, 99) < 55);
        n_lsurd  = 5'($urandom_range(0, 31));
        n_lsud   = $urandom;
      end
      applyStimulus(ex_pend, n_exrd, n_exd, lsu_pend, n_lsurd, n_lsud,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (exp_exg)  ex_pend  = 1'b0;
      if (exp_lsug) lsu_pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
